// File: rtl/char_sprite_addr_gen_if.sv
// Scan-position, character-position and sprite-address bundle for the sprite address stage.
interface char_sprite_addr_gen_if;
    logic        frame_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  Player_X;
    logic [9:0]  Player_Y;
    logic        Player_facing_left;
    logic [9:0]  NPC_X;
    logic [9:0]  NPC_Y;
    logic        NPC_facing_left;
    logic        player_hit;
    logic        npc_hit;
    logic [11:0] Player_address;
    logic [11:0] NPC_address;
    logic        player_in_box;
    logic        npc_in_box;
    logic        player_blinking;
    logic        npc_blinking;

    modport master (
        output frame_clk, DrawX, DrawY, Player_X, Player_Y, Player_facing_left,
               NPC_X, NPC_Y, NPC_facing_left, player_hit, npc_hit,
        input  Player_address, NPC_address, player_in_box, npc_in_box,
               player_blinking, npc_blinking
    );

    modport slave (
        input  frame_clk, DrawX, DrawY, Player_X, Player_Y, Player_facing_left,
               NPC_X, NPC_Y, NPC_facing_left, player_hit, npc_hit,
        output Player_address, NPC_address, player_in_box, npc_in_box,
               player_blinking, npc_blinking
    );
endinterface

// File: rtl/char_sprite_addr_gen.sv
// Turns the scan position into per-character sprite ROM addresses and in-box flags,
// with per-frame position latching, left-facing mirroring and a hit-blink state machine.
module char_sprite_addr_gen #(
    parameter int unsigned SPRITE_W     = 41,
    parameter int unsigned SPRITE_H     = 65,
    parameter int unsigned BLINK_FRAMES = 48,
    parameter int unsigned BLINK_BIT    = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    char_sprite_addr_gen_if.slave bus
);
    localparam int unsigned CW    = 11;
    localparam int unsigned AW    = 12;
    localparam int unsigned CNT_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] HIDE_MASK = CNT_W'(1) << BLINK_BIT;

    typedef enum logic {IDLE, BLINK} blink_state_t;

    // Box test and address for one character; result is {hit, address}.
    function automatic logic [AW:0] sprite_lookup(input logic [9:0] dx, input logic [9:0] dy,
                                                  input logic [9:0] x,  input logic [9:0] y,
                                                  input logic fl);
        logic [CW-1:0] xs, ys, col, row;
        logic          hit;
        logic [AW-1:0] colp, addr;
        xs   = CW'(x);
        ys   = CW'(y);
        col  = CW'(dx) - xs;
        row  = CW'(dy) - ys;
        hit  = (CW'(dx) >= xs) && (CW'(dx) < xs + CW'(SPRITE_W)) &&
               (CW'(dy) >= ys) && (CW'(dy) < ys + CW'(SPRITE_H));
        colp = fl ? (AW'(SPRITE_W - 1) - AW'(col)) : AW'(col);
        addr = hit ? (AW'(row) * AW'(SPRITE_W) + colp) : '0;
        return {hit, addr};
    endfunction

    logic                r_frame_q;
    logic [9:0]          r_x [2];
    logic [9:0]          r_y [2];
    logic                r_fl [2];
    blink_state_t        r_state [2];
    logic [CNT_W-1:0]    r_cnt [2];
    logic                r_blink [2];
    logic [AW-1:0]       r_addr [2];
    logic                r_in_box [2];

    logic                w_frame_rise;
    logic [9:0]          w_pos_x [2];
    logic [9:0]          w_pos_y [2];
    logic                w_pos_fl [2];
    logic                w_hit_pulse [2];
    logic [AW:0]         w_look [2];
    logic                w_hidden [2];

    assign w_frame_rise   = bus.frame_clk & ~r_frame_q;
    assign w_pos_x[0]     = bus.Player_X;
    assign w_pos_x[1]     = bus.NPC_X;
    assign w_pos_y[0]     = bus.Player_Y;
    assign w_pos_y[1]     = bus.NPC_Y;
    assign w_pos_fl[0]    = bus.Player_facing_left;
    assign w_pos_fl[1]    = bus.NPC_facing_left;
    assign w_hit_pulse[0] = bus.player_hit;
    assign w_hit_pulse[1] = bus.npc_hit;

    // Address math only ever sees the frame-latched shadow positions.
    assign w_look[0]   = sprite_lookup(bus.DrawX, bus.DrawY, r_x[0], r_y[0], r_fl[0]);
    assign w_look[1]   = sprite_lookup(bus.DrawX, bus.DrawY, r_x[1], r_y[1], r_fl[1]);
    assign w_hidden[0] = (r_state[0] == BLINK) && |(r_cnt[0] & HIDE_MASK);
    assign w_hidden[1] = (r_state[1] == BLINK) && |(r_cnt[1] & HIDE_MASK);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_x[i]      <= '0;
                r_y[i]      <= '0;
                r_fl[i]     <= 1'b0;
                r_state[i]  <= IDLE;
                r_cnt[i]    <= '0;
                r_blink[i]  <= 1'b0;
                r_addr[i]   <= '0;
                r_in_box[i] <= 1'b0;
            end
        end else begin
            r_frame_q <= bus.frame_clk;
            for (int i = 0; i < 2; i++) begin
                if (w_frame_rise) begin
                    r_x[i]  <= w_pos_x[i];
                    r_y[i]  <= w_pos_y[i];
                    r_fl[i] <= w_pos_fl[i];
                end
                r_addr[i]   <= w_look[i][AW-1:0];
                r_in_box[i] <= w_look[i][AW] && !w_hidden[i];
                // Hits while blinking are ignored; a hit always wins over a frame edge in IDLE.
                case (r_state[i])
                    IDLE: begin
                        if (w_hit_pulse[i]) begin
                            r_state[i] <= BLINK;
                            r_cnt[i]   <= CNT_W'(BLINK_FRAMES);
                            r_blink[i] <= 1'b1;
                        end
                    end
                    BLINK: begin
                        if (w_frame_rise) begin
                            if (r_cnt[i] == CNT_W'(1)) begin
                                r_state[i] <= IDLE;
                                r_cnt[i]   <= '0;
                                r_blink[i] <= 1'b0;
                            end else begin
                                r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.Player_address  = r_addr[0];
    assign bus.NPC_address     = r_addr[1];
    assign bus.player_in_box   = r_in_box[0];
    assign bus.npc_in_box      = r_in_box[1];
    assign bus.player_blinking = r_blink[0];
    assign bus.npc_blinking    = r_blink[1];
endmodule
